// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 pipeline read-request stage.
package aes128_pkg;

  localparam int unsigned RD_MAX_OUTSTANDING = 8;
  localparam int unsigned RD_ADDR_W          = 42;
  localparam int unsigned BLOCK_W            = 512;
  localparam logic [15:0] RD_KEY_MDATA       = 16'h8000;

  typedef logic [5:0]         t_rd_tag;
  typedef logic [BLOCK_W-1:0] t_block;

  typedef enum logic [2:0] {
    S_RD_IDLE,
    S_RD_FETCH_KEY,
    S_RD_FETCH,
    S_RD_WAIT,
    S_RD_FINISH
  } t_rd_state;

  typedef struct packed {
    logic [RD_ADDR_W-1:0] addr;
    logic [15:0]          mdata;
  } t_rd_req;

endpackage

// File: rtl/aes128_rd_rob.sv
// Reorder buffer: written by tag in any order, read in order through the head slot.
module aes128_rd_rob
  import aes128_pkg::*;
#(
  parameter int unsigned DEPTH = RD_MAX_OUTSTANDING,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  t_block           wr_data_i,
  input  logic [IDX_W-1:0] chk_idx_i,
  output logic             chk_free_o,
  output logic             head_full_o,
  output t_block           head_data_o,
  input  logic             pop_i
);

  logic [DEPTH-1:0] full_q, full_d;
  logic [IDX_W-1:0] head_q, head_d;
  t_block           mem_q [DEPTH];

  // Full-bit and head-pointer update; clear wins over everything.
  always_comb begin
    full_d = full_q;
    head_d = head_q;
    if (clr_i) begin
      full_d = '0;
      head_d = '0;
    end else begin
      if (pop_i) begin
        full_d[head_q] = 1'b0;
        head_d         = IDX_W'(head_q + 1'b1);
      end
      if (wr_en_i) full_d[wr_idx_i] = 1'b1;
    end
  end

  // Full bits and head pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      head_q <= '0;
    end else begin
      full_q <= full_d;
      head_q <= head_d;
    end
  end

  // Line storage; contents are only meaningful where the full bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign chk_free_o  = !full_q[chk_idx_i];
  assign head_full_o = full_q[head_q];
  assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/aes128_rd_engine.sv
// Read-request stage: fetches the key line, streams source lines over c0 and
// reorders responses into address-ordered blocks.
// Optional perf counters enabled by defining AES128_RD_PERF_EN.
module aes128_rd_engine
  import aes128_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = RD_MAX_OUTSTANDING,
  parameter int unsigned ADDR_W          = RD_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] key_addr,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [31:0]       src_size,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [15:0]       rd_req_mdata,
  input  logic              rd_almost_full,
  input  logic              rd_rsp_valid,
  input  logic [15:0]       rd_rsp_mdata,
  input  logic [511:0]      rd_rsp_data,
  output logic              key_valid,
  output logic [127:0]      key_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [511:0]      blk_data,
  output logic              blk_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
);

  localparam int unsigned IDX_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = IDX_W + 1;

  t_rd_state         state_q, state_d;
  logic [ADDR_W-1:0] key_addr_q, key_addr_d, src_addr_q, src_addr_d;
  logic [31:0]       src_size_q, src_size_d;
  logic [31:0]       issue_idx_q, issue_idx_d, drain_idx_q, drain_idx_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              abort_q, abort_d;
  logic              key_valid_q, key_valid_d;
  logic [127:0]      key_data_q, key_data_d;
  logic              req_valid_q, req_valid_d;
  t_rd_req           req_q, req_d;

  logic             rsp_key, rsp_dat, rob_wr, rob_clr, pop;
  logic             key_fire, issue_fire, stall, slot_free, head_full, dec;
  logic [IDX_W-1:0] issue_slot;
  t_block           head_data;
  logic             unused_mdata;

  assign issue_slot   = issue_idx_q[IDX_W-1:0];
  assign rsp_key      = rd_rsp_valid && rd_rsp_mdata[15] && busy;
  assign rsp_dat      = rd_rsp_valid && !rd_rsp_mdata[15] && busy;
  assign rob_wr       = rsp_dat && !abort_q;
  assign dec          = rsp_dat && (outst_q != '0);
  assign unused_mdata = ^rd_rsp_mdata[14:IDX_W];

  aes128_rd_rob #(.DEPTH(MAX_OUTSTANDING)) u_rob (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (rob_clr),
    .wr_en_i    (rob_wr),
    .wr_idx_i   (rd_rsp_mdata[IDX_W-1:0]),
    .wr_data_i  (rd_rsp_data),
    .chk_idx_i  (issue_slot),
    .chk_free_o (slot_free),
    .head_full_o(head_full),
    .head_data_o(head_data),
    .pop_i      (pop)
  );

  // Next-state, request issue, key capture and bookkeeping.
  always_comb begin
    state_d     = state_q;
    key_addr_d  = key_addr_q;
    src_addr_d  = src_addr_q;
    src_size_d  = src_size_q;
    issue_idx_d = issue_idx_q;
    drain_idx_d = drain_idx_q;
    outst_d     = outst_q;
    abort_d     = abort_q;
    key_valid_d = key_valid_q;
    key_data_d  = key_data_q;
    req_valid_d = 1'b0;
    req_d       = req_q;
    rob_clr     = 1'b0;
    key_fire    = 1'b0;
    issue_fire  = 1'b0;
    stall       = 1'b0;

    case (state_q)
      S_RD_IDLE: begin
        if (start) begin
          key_addr_d  = key_addr;
          src_addr_d  = src_addr;
          src_size_d  = src_size;
          issue_idx_d = '0;
          drain_idx_d = '0;
          abort_d     = 1'b0;
          key_valid_d = 1'b0;
          key_data_d  = '0;
          rob_clr     = 1'b1;
          state_d     = S_RD_FETCH_KEY;
        end
      end
      S_RD_FETCH_KEY: begin
        if (stop) begin
          abort_d = 1'b1;
          state_d = S_RD_WAIT;
        end else if (!rd_almost_full) begin
          key_fire = 1'b1;
          state_d  = (src_size_q == '0) ? S_RD_WAIT : S_RD_FETCH;
        end
      end
      S_RD_FETCH: begin
        if (stop) begin
          abort_d = 1'b1;
          state_d = S_RD_WAIT;
        end else if (outst_q < CNT_W'(MAX_OUTSTANDING) && slot_free) begin
          if (rd_almost_full) begin
            stall = 1'b1;
          end else begin
            issue_fire  = 1'b1;
            issue_idx_d = issue_idx_q + 32'd1;
            if (issue_idx_q == src_size_q - 32'd1) state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (abort_q || stop) begin
          abort_d = 1'b1;
          if (outst_q == '0) state_d = S_RD_IDLE;
        end else if (key_valid_q && drain_idx_q == src_size_q && outst_q == '0) begin
          state_d = S_RD_FINISH;
        end
      end
      S_RD_FINISH: state_d = S_RD_IDLE;
      default:     state_d = S_RD_IDLE;
    endcase

    if (key_fire) begin
      req_valid_d = 1'b1;
      req_d.addr  = RD_ADDR_W'(key_addr_q);
      req_d.mdata = RD_KEY_MDATA;
    end
    if (issue_fire) begin
      req_valid_d = 1'b1;
      req_d.addr  = RD_ADDR_W'(src_addr_q + ADDR_W'(issue_idx_q));
      req_d.mdata = {10'b0, t_rd_tag'(issue_slot)};
    end

    if (rsp_key && !abort_q) begin
      key_valid_d = 1'b1;
      key_data_d  = rd_rsp_data[127:0];
    end

    case ({issue_fire, dec})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (pop) drain_idx_d = drain_idx_q + 32'd1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RD_IDLE;
      key_addr_q  <= '0;
      src_addr_q  <= '0;
      src_size_q  <= '0;
      issue_idx_q <= '0;
      drain_idx_q <= '0;
      outst_q     <= '0;
      abort_q     <= 1'b0;
      key_valid_q <= 1'b0;
      key_data_q  <= '0;
      req_valid_q <= 1'b0;
      req_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_addr_q  <= key_addr_d;
      src_addr_q  <= src_addr_d;
      src_size_q  <= src_size_d;
      issue_idx_q <= issue_idx_d;
      drain_idx_q <= drain_idx_d;
      outst_q     <= outst_d;
      abort_q     <= abort_d;
      key_valid_q <= key_valid_d;
      key_data_q  <= key_data_d;
      req_valid_q <= req_valid_d;
      req_q       <= req_d;
    end
  end

  assign busy         = (state_q != S_RD_IDLE);
  assign done         = (state_q == S_RD_FINISH);
  assign rd_req_valid = req_valid_q;
  assign rd_req_addr  = ADDR_W'(req_q.addr);
  assign rd_req_mdata = req_q.mdata;
  assign key_valid    = key_valid_q;
  assign key_data     = key_data_q;
  // Head block is held back until the key is known and suppressed after a stop.
  assign blk_valid    = head_full && key_valid_q && !abort_q && busy;
  assign blk_data     = head_data;
  assign blk_last     = blk_valid && (drain_idx_q == src_size_q - 32'd1);
  assign pop          = blk_valid && blk_ready;

`ifdef AES128_RD_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;

  // Saturating busy-cycle and almost-full stall counters, cleared on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == S_RD_IDLE && start) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy && perf_cycles_q != '1)  perf_cycles_q <= perf_cycles_q + 32'd1;
      if (stall && perf_stalls_q != '1) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  logic unused_perf;
  assign unused_perf = stall;
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_aes128_rd_engine.sv
// Directed bench for aes128_rd_engine: vector table of jobs plus hand-written
// almost-full, stop and reset sequences.
module tb_aes128_rd_engine;

  localparam int unsigned AW = 42;
  localparam int unsigned MO = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, stop;
  logic [AW-1:0] key_addr, src_addr;
  logic [31:0]   src_size;
  logic          rd_req_valid;
  logic [AW-1:0] rd_req_addr;
  logic [15:0]   rd_req_mdata;
  logic          rd_almost_full, rd_rsp_valid;
  logic [15:0]   rd_rsp_mdata;
  logic [511:0]  rd_rsp_data;
  logic          key_valid;
  logic [127:0]  key_data;
  logic          blk_valid, blk_ready;
  logic [511:0]  blk_data;
  logic          blk_last, busy, done;
  logic [31:0]   perf_cycles, perf_stalls;

  aes128_rd_engine #(.MAX_OUTSTANDING(MO), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .key_addr(key_addr), .src_addr(src_addr), .src_size(src_size),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
    .rd_almost_full(rd_almost_full), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .key_valid(key_valid), .key_data(key_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .busy(busy), .done(done), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] key_a;
    logic [AW-1:0] src_a;
    int            size;
    logic [31:0]   order;      // nibble k = tag of k-th data response
    bit            key_first;
    bit            bp;
  } vec_t;

  vec_t          vecs[6];
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [AW-1:0] req_addr_q[$];
  logic [15:0]   req_md_q[$];
  logic [511:0]  blk_q[$];
  logic          blk_last_q[$];
  int            done_cnt = 0;
  int            busy_cnt = 0;
  bit            bp_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [511:0]  prev_data;

  function automatic logic [511:0] line_data(input logic [AW-1:0] a);
    logic [511:0] d;
    for (int w = 0; w < 16; w++)
      d[w*32 +: 32] = a[31:0] ^ (32'h9E3779B9 * 32'(w + 1)) ^ {22'd0, a[41:32]};
    return d;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream backpressure source.
  always @(posedge clk) begin
    #1;
    blk_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Request/block/done monitor and blk hold check.
  always @(negedge clk) begin
    if (rd_req_valid) begin
      req_addr_q.push_back(rd_req_addr);
      req_md_q.push_back(rd_req_mdata);
    end
    if (blk_valid && blk_ready) begin
      blk_q.push_back(blk_data);
      blk_last_q.push_back(blk_last);
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (prev_stall) begin
      check("blk_hold_valid", 512'(blk_valid), 512'(1'b1));
      check("blk_hold_data", blk_data, prev_data);
    end
    prev_stall = blk_valid && !blk_ready;
    prev_data  = blk_data;
  end

  task automatic do_start(input logic [AW-1:0] ka, input logic [AW-1:0] sa, input int sz);
    req_addr_q.delete(); req_md_q.delete(); blk_q.delete(); blk_last_q.delete();
    @(posedge clk); #1;
    done_cnt = 0; busy_cnt = 0;
    key_addr = ka; src_addr = sa; src_size = 32'(sz); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_rsp(input logic [15:0] md, input logic [511:0] d);
    @(posedge clk); #1;
    rd_rsp_valid = 1'b1; rd_rsp_mdata = md; rd_rsp_data = d;
    @(posedge clk); #1;
    rd_rsp_valid = 1'b0;
  endtask

  task automatic wait_check_reqs(input logic [AW-1:0] ka, input logic [AW-1:0] sa, input int sz);
    logic [AW-1:0] ea;
    for (int c = 0; c < 300 && req_addr_q.size() < sz + 1; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("req_count", 512'(req_addr_q.size()), 512'(sz + 1));
    for (int i = 0; i < req_addr_q.size(); i++) begin
      if (i == 0) begin
        check("key_req_addr", 512'(req_addr_q[0]), 512'(ka));
        check("key_req_mdata", 512'(req_md_q[0]), 512'(16'h8000));
      end else begin
        ea = sa + AW'(i - 1);
        check("req_addr", 512'(req_addr_q[i]), 512'(ea));
        check("req_mdata", 512'(req_md_q[i]), 512'(16'((i - 1) % MO)));
      end
    end
  endtask

  task automatic respond(input logic [AW-1:0] ka, input logic [AW-1:0] sa, input int sz,
                         input logic [31:0] order, input bit key_first);
    int t;
    if (key_first) send_rsp(16'h8000, line_data(ka));
    for (int k = 0; k < sz; k++) begin
      t = int'(order[4*k +: 4]);
      send_rsp(16'(t), line_data(sa + AW'(t)));
    end
    if (!key_first) begin
      repeat (6) @(negedge clk);
      check("no_blk_before_key", 512'(blk_q.size()), 512'(0));
      check("blk_valid_before_key", 512'(blk_valid), 512'(1'b0));
      send_rsp(16'h8000, line_data(ka));
    end
  endtask

  task automatic wait_done_check(input logic [AW-1:0] ka, input logic [AW-1:0] sa, input int sz);
    logic [511:0] kd;
    logic [AW-1:0] ea;
    kd = line_data(ka);
    for (int c = 0; c < 400 && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_pulses", 512'(done_cnt), 512'(1));
    check("busy_after_done", 512'(busy), 512'(1'b0));
    check("key_valid", 512'(key_valid), 512'(1'b1));
    check("key_data", 512'(key_data), 512'(kd[127:0]));
    check("blk_count", 512'(blk_q.size()), 512'(sz));
    for (int i = 0; i < blk_q.size(); i++) begin
      ea = sa + AW'(i);
      check("blk_data", blk_q[i], line_data(ea));
      check("blk_last", 512'(blk_last_q[i]), 512'(i == sz - 1));
    end
  endtask

  initial begin
    int ndata;
    vecs[0] = '{42'h100, 42'h2000, 4, 32'h0000_3210, 1'b1, 1'b0};
    vecs[1] = '{42'h140, 42'h3000, 8, 32'h4562_1037, 1'b1, 1'b1};
    vecs[2] = '{42'h180, 42'h4000, 8, 32'h0123_4567, 1'b0, 1'b0};
    vecs[3] = '{42'h1C0, 42'h5000, 0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{42'h200, 42'h3FF_FFFF_FFFE, 4, 32'h0000_1302, 1'b1, 1'b1};
    vecs[5] = '{42'h240, 42'h6000, 3, 32'h0000_0012, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; key_addr = '0; src_addr = '0; src_size = '0;
    rd_almost_full = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 512'(busy), 512'(1'b0));
    check("rst_req_valid", 512'(rd_req_valid), 512'(1'b0));
    check("rst_key_valid", 512'(key_valid), 512'(1'b0));
    check("rst_blk_valid", 512'(blk_valid), 512'(1'b0));
    check("rst_done", 512'(done), 512'(1'b0));
    check("rst_perf", 512'({perf_cycles, perf_stalls}), 512'(0));
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].key_a, vecs[v].src_a, vecs[v].size);
      bp_en = vecs[v].bp;
      wait_check_reqs(vecs[v].key_a, vecs[v].src_a, vecs[v].size);
      respond(vecs[v].key_a, vecs[v].src_a, vecs[v].size, vecs[v].order, vecs[v].key_first);
      wait_done_check(vecs[v].key_a, vecs[v].src_a, vecs[v].size);
      bp_en = 1'b0;
    end

    // Almost-full held for 20 cycles right after the key request.
    do_start(42'h280, 42'h7000, 4);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rd_req_valid) break;
    end
    check("af_key_seen", 512'(rd_req_valid), 512'(1'b1));
    rd_almost_full = 1'b1;
    ndata = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_req_valid) ndata++;
    end
    rd_almost_full = 1'b0;
    check("af_no_req", 512'(ndata), 512'(0));
    wait_check_reqs(42'h280, 42'h7000, 4);
    respond(42'h280, 42'h7000, 4, 32'h0000_3210, 1'b1);
    wait_done_check(42'h280, 42'h7000, 4);
`ifdef AES128_RD_PERF_EN
    check("perf_stalls", 512'(perf_stalls), 512'(20));
    check("perf_cycles", 512'(perf_cycles), 512'(busy_cnt));
`else
    check("perf_stalls_off", 512'(perf_stalls), 512'(0));
    check("perf_cycles_off", 512'(perf_cycles), 512'(0));
`endif

    // Stop after three data requests of sixteen.
    do_start(42'h2C0, 42'h8000, 16);
    ndata = 0;
    for (int c = 0; c < 100 && ndata < 3; c++) begin
      @(negedge clk);
      rd_rsp_valid = 1'b0;
      if (rd_req_valid) begin
        if (rd_req_mdata[15]) begin
          rd_rsp_valid = 1'b1; rd_rsp_mdata = 16'h8000; rd_rsp_data = line_data(42'h2C0);
        end else begin
          ndata++;
        end
      end
    end
    stop = 1'b1;
    rd_rsp_valid = 1'b0;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_reached3", 512'(ndata), 512'(3));
    repeat (10) @(negedge clk);
    check("stop_req_count", 512'(req_addr_q.size()), 512'(4));
    check("stop_busy_held", 512'(busy), 512'(1'b1));
    send_rsp(16'd0, line_data(42'h8000));
    send_rsp(16'd1, line_data(42'h8001));
    @(negedge clk);
    check("stop_busy_2rsp", 512'(busy), 512'(1'b1));
    check("stop_blk_valid", 512'(blk_valid), 512'(1'b0));
    send_rsp(16'd2, line_data(42'h8002));
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    check("stop_busy_drop", 512'(busy), 512'(1'b0));
    repeat (3) @(negedge clk);
    check("stop_no_done", 512'(done_cnt), 512'(0));
    check("stop_no_blk", 512'(blk_q.size()), 512'(0));

    // A normal job right after an aborted one.
    do_start(vecs[0].key_a, vecs[0].src_a, vecs[0].size);
    wait_check_reqs(vecs[0].key_a, vecs[0].src_a, vecs[0].size);
    respond(vecs[0].key_a, vecs[0].src_a, vecs[0].size, vecs[0].order, 1'b1);
    wait_done_check(vecs[0].key_a, vecs[0].src_a, vecs[0].size);

    // Reset mid-operation, then late responses must be ignored.
    do_start(42'h300, 42'h9000, 4);
    ndata = 0;
    for (int c = 0; c < 50 && ndata < 3; c++) begin
      @(negedge clk);
      if (rd_req_valid) ndata++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 512'(busy), 512'(1'b0));
    check("midrst_req_valid", 512'(rd_req_valid), 512'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    send_rsp(16'h8000, line_data(42'h300));
    send_rsp(16'd0, line_data(42'h9000));
    repeat (3) @(negedge clk);
    check("late_key_valid", 512'(key_valid), 512'(1'b0));
    check("late_blk_valid", 512'(blk_valid), 512'(1'b0));
    check("late_busy", 512'(busy), 512'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
